pipeline_ctrl: RTL and testbench

Per-stage enable/flush controller for the five-stage MIPS pipeline. It consumes the load-use `stall` from the hazard unit, the branch/jump resolution, the cache hit signals and `halt`, and drives the write-enable and flush inputs of the PC and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). A small FSM tracks outstanding data-memory requests and the halted state. Saturating counters record stall cycles and branch flushes for performance reporting.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/sat_counter.sv | 24 ++
 rtl/pipeline_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions used across the pipeline control logic.
package cpu_types_pkg;

    // Pipeline controller state: normal flow, waiting on dcache, halted.
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DWAIT = 2'b01,
        HALT  = 2'b10
    } ctrl_state_t;

    // Default performance counter width.
    localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Per-stage enable/flush controller for the five-stage pipeline, with a
// small FSM tracking outstanding dcache requests and the halted state.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             stall,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN,
    input  logic             dmemWEN,
    input  logic             halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t r_state;
    ctrl_state_t w_next;
    logic        w_dreq;
    logic        w_flush_inc;
    logic        w_stall_inc;

    assign w_dreq = dmemREN | dmemWEN;

    // State register; HALT is only left through reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Prioritised enable/flush decode and next-state selection.
    always_comb begin
        w_next      = r_state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        w_flush_inc = 1'b0;
        // Everything stays frozen while reset is held.
        if (nRST && (r_state != HALT)) begin
            if (halt) begin
                w_next = HALT;
            end else if (!dhit && (w_dreq || (r_state == DWAIT))) begin
                // Memory busy: freeze the whole pipe until the dcache answers.
                w_next = DWAIT;
            end else begin
                w_next = RUN;
                if (branch_taken) begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    w_flush_inc = 1'b1;
                end else if (stall) begin
                    // Hold PC and IF/ID, push a bubble into ID/EX.
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (!ihit && (r_state == RUN)) begin
                    // Icache miss: hold PC, bubble into IF/ID.
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (jump) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
            end
        end
    end

    // Any non-halted cycle that holds the PC counts as a stall cycle.
    assign w_stall_inc = (r_state != HALT) && !pc_en;

    assign halted = (r_state == HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; narrow counters make saturation reachable.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    logic          CLK;
    logic          nRST;
    logic          stall, jump, branch_taken, ihit, dhit, dmemREN, dmemWEN, halt;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [7:0]    ctl;

    int n_cmp;
    int n_bad;

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .stall        (stall),
        .jump         (jump),
        .branch_taken (branch_taken),
        .ihit         (ihit),
        .dhit         (dhit),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .halt         (halt),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem flushes}
    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        stall = 0; jump = 0; branch_taken = 0; ihit = 1;
        dhit = 0; dmemREN = 0; dmemWEN = 0; halt = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nRST  = 1'b0;
        clear_in();

        // Reset state
        #3;
        check("rst_ctl", 32'(ctl), 32'h00);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        tick();
        nRST = 1'b1;

        // Idle: everything flows
        for (int i = 0; i < 10; i++) begin
            #2 check("idle_ctl", 32'(ctl), 32'hF8);
            tick();
        end
        check("idle_stall_cnt", 32'(stall_cnt), 32'h0);
        check("idle_flush_cnt", 32'(flush_cnt), 32'h0);

        // dcache miss for 3 cycles, then hit
        dmemREN = 1;
        for (int i = 0; i < 3; i++) begin
            #2 check("dmiss_ctl", 32'(ctl), 32'h00);
            tick();
        end
        dhit = 1;
        #2 check("dhit_ctl", 32'(ctl), 32'hF8);
        tick();
        check("dmiss_stall_cnt", 32'(stall_cnt), 32'h3);
        clear_in();

        // Load-use stall
        stall = 1;
        #2 check("stall_ctl", 32'(ctl), 32'h3A);
        tick();
        check("stall_stall_cnt", 32'(stall_cnt), 32'h4);

        // Stall beats jump, then jump re-resolves
        jump = 1;
        #2 check("stall_jump_ctl", 32'(ctl), 32'h3A);
        tick();
        stall = 0;
        #2 check("jump_ctl", 32'(ctl), 32'hFC);
        tick();
        check("jump_stall_cnt", 32'(stall_cnt), 32'h5);
        clear_in();

        // Icache miss
        ihit = 0;
        #2 check("imiss_ctl", 32'(ctl), 32'h7C);
        tick();
        check("imiss_stall_cnt", 32'(stall_cnt), 32'h6);

        // Branch beats stall and icache miss
        stall = 1; branch_taken = 1;
        #2 check("branch_ctl", 32'(ctl), 32'hFF);
        tick();
        check("branch_flush_cnt", 32'(flush_cnt), 32'h1);
        check("branch_stall_cnt", 32'(stall_cnt), 32'h6);
        clear_in();

        // Halt beats branch and pending dcache miss
        halt = 1; branch_taken = 1; dmemREN = 1;
        #2 check("halt_ctl", 32'(ctl), 32'h00);
        check("halt_pre_halted", 32'(halted), 32'h0);
        tick();
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_flush_cnt", 32'(flush_cnt), 32'h1);
        check("halt_stall_cnt", 32'(stall_cnt), 32'h7);
        clear_in();
        stall = 1; branch_taken = 1;
        for (int i = 0; i < 20; i++) begin
            #2 check("halted_ctl", 32'(ctl), 32'h00);
            tick();
            check("halted_sticky", 32'(halted), 32'h1);
        end
        check("halted_stall_cnt", 32'(stall_cnt), 32'h7);
        check("halted_flush_cnt", 32'(flush_cnt), 32'h1);

        // Asynchronous reset mid-cycle while halted
        #2 nRST = 1'b0;
        #1;
        check("arst_halted", 32'(halted), 32'h0);
        check("arst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("arst_flush_cnt", 32'(flush_cnt), 32'h0);
        check("arst_ctl", 32'(ctl), 32'h00);
        tick();
        clear_in();
        nRST = 1'b1;
        #2 check("post_rst_ctl", 32'(ctl), 32'hF8);
        tick();

        // flush_cnt saturation: 15 pulses reach all-ones, one more holds
        branch_taken = 1;
        for (int i = 0; i < 15; i++) tick();
        check("flush_sat_reach", 32'(flush_cnt), 32'hF);
        tick();
        check("flush_sat_hold", 32'(flush_cnt), 32'hF);
        clear_in();

        // stall_cnt saturation
        stall = 1;
        for (int i = 0; i < 17; i++) tick();
        check("stall_sat_hold", 32'(stall_cnt), 32'hF);
        clear_in();
        #2 check("final_ctl", 32'(ctl), 32'hF8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
